// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory port between the core's instruction-fetch requester
// and its load/store requester.  Only one transaction is in flight at a time.
// Data requests normally win, but fetch is forced through after STARVE_LIMIT
// consecutive data grants that happened while fetch was waiting.  Each memory
// response is routed back to the requester that owns the outstanding
// transaction.
//
// Handshake semantics, shared by both requesters and by the memory side:
//   A requester raises *_req_i with its address/attributes and holds them
//   until it sees *_gnt_o high in the same cycle.  A grant is issued
//   combinationally, only while the arbiter is idle.  At most one grant is
//   issued per cycle.  The granted request is copied into internal registers,
//   and those registers alone drive mem_adr_o/mem_we_o/mem_wdata_o/mem_size_o.
//   mem_req_o stays high with stable attributes until the memory answers with
//   mem_gnt_i.  Exactly one response (mem_rvalid_i) is then taken.  It appears
//   on the owner's *_rvalid_o/*_rdata_o in the same cycle.  A store also
//   returns one d_rvalid_o as its acknowledge.
//
// Ports
//   clk, reset_n                 core clock, synchronous active-low reset
//   if_req_i/if_adr_i            fetch request and address
//   if_gnt_o                     fetch request accepted this cycle
//   if_rvalid_o/if_rdata_o       fetch response
//   d_req_i/d_adr_i/d_we_i       data request, address, write enable
//   d_wdata_i/d_size_i           store data, access size (forwarded as is)
//   d_gnt_o                      data request accepted this cycle
//   d_rvalid_o/d_rdata_o         load data / store acknowledge
//   mem_req_o ... mem_size_o     request to the unified memory
//   mem_gnt_i                    memory accepted the request
//   mem_rvalid_i/mem_rdata_i     memory response
//   dbg_state                    FSM state: 0 = idle, 1 = request, 2 = response
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,

    input  logic            d_req_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [2:0]      d_size_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,

    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // Fetch is always a 32-bit word read.
    localparam logic [2:0]       FETCH_SIZE = 3'b010;

    state_t            state;
    owner_t            owner;
    logic [CNT_W-1:0]  starve_cnt;
    logic              mem_req_q;
    logic [XLEN-1:0]   adr_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        size_q;

    logic              idle_ok;
    logic              fetch_forced;
    logic              if_win;
    logic              d_win;
    logic              resp_fire;

    // ------------------------------------------------------------------
    // Arbitration.  Grants are combinational so that a requester sees its
    // grant in the same cycle it is accepted.  Gating with reset_n keeps
    // every output low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        idle_ok      = reset_n && (state == ST_IDLE);
        fetch_forced = if_req_i && (starve_cnt == STARVE_MAX);
        if_win       = idle_ok && if_req_i && (!d_req_i || fetch_forced);
        d_win        = idle_ok && d_req_i && !if_win;
    end

    assign if_gnt_o = if_win;
    assign d_gnt_o  = d_win;

    // ------------------------------------------------------------------
    // Response routing.  Only a response arriving in the RESP state
    // belongs to the outstanding transaction.  A response in any other
    // state is ignored.  This includes a response that arrives together
    // with mem_gnt_i, or one that belongs to a transaction cut off by reset.
    // ------------------------------------------------------------------
    always_comb begin
        resp_fire   = reset_n && (state == ST_RESP) && mem_rvalid_i;
        if_rvalid_o = resp_fire && (owner == OWN_IF);
        d_rvalid_o  = resp_fire && (owner == OWN_D);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i[31:0] : 32'd0;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i       : '0;
    end

    // Memory side is driven purely from registers so the request stays
    // stable while the memory stalls.
    assign mem_req_o   = mem_req_q;
    assign mem_adr_o   = adr_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;
    assign mem_size_o  = size_q;
    assign dbg_state   = state;

    // ------------------------------------------------------------------
    // Transaction FSM: IDLE -> REQ -> RESP -> IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
            mem_req_q  <= 1'b0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            size_q     <= 3'b000;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (if_win) begin
                        adr_q      <= if_adr_i;
                        we_q       <= 1'b0;
                        wdata_q    <= '0;
                        size_q     <= FETCH_SIZE;
                        owner      <= OWN_IF;
                        starve_cnt <= '0;
                        mem_req_q  <= 1'b1;
                        state      <= ST_REQ;
                    end else if (d_win) begin
                        adr_q     <= d_adr_i;
                        we_q      <= d_we_i;
                        wdata_q   <= d_wdata_i;
                        size_q    <= d_size_i;
                        owner     <= OWN_D;
                        mem_req_q <= 1'b1;
                        state     <= ST_REQ;
                        // Count only the data grants that made fetch wait.
                        if (if_req_i && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (mem_rvalid_i) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    mem_req_q <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for mem_port_arbiter.
//
// The bench drives both requesters and the memory.  A transaction-level
// reference model predicts every DUT output in every cycle.  The model
// tracks whether the port is free, issued, or waiting for data, along with
// the current owner, the latched request, and the count of fetch-starving
// data grants.  A scoreboard queue pairs each grant with the response that
// should come back for it.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int XLEN         = 32;
    localparam int STARVE_LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic            if_req_i;
    logic [XLEN-1:0] if_adr_i;
    logic            if_gnt_o, if_rvalid_o;
    logic [31:0]     if_rdata_o;
    logic            d_req_i;
    logic [XLEN-1:0] d_adr_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_wdata_i;
    logic [2:0]      d_size_i;
    logic            d_gnt_o, d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_adr_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [2:0]      mem_size_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic [1:0]      dbg_state;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i),
        .d_wdata_i(d_wdata_i), .d_size_i(d_size_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .dbg_state(dbg_state)
    );

    // ---------------- counters / scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    // {owner_is_data, address} of each granted transaction awaiting response
    logic [XLEN:0] exp_q[$];
    // expected owner sequence for the starvation pattern (1 = data)
    logic [0:0]    pat_q[$];

    // ---------------- reference model ----------------
    // m_stage: 0 = port free, 1 = request shown to memory, 2 = awaiting data
    int              m_stage;
    logic            m_owner_d;
    int              m_starve;
    logic [XLEN-1:0] m_adr, m_wdata;
    logic            m_we;
    logic [2:0]      m_size;
    logic            g_if, g_d;          // model grants in the last cycle
    logic            obs_if_gnt, obs_d_gnt;

    task automatic model_clear();
        m_stage   = 0;
        m_owner_d = 1'b0;
        m_starve  = 0;
        m_adr     = '0;
        m_wdata   = '0;
        m_we      = 1'b0;
        m_size    = 3'b000;
        exp_q.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: check all outputs mid-cycle against the model, then
    // advance the model as the clock edge does.  Inputs for the next cycle
    // are driven by the caller after return (posedge + 1).
    task automatic cycle();
        logic          eg_if, eg_d, erv_if, erv_d;
        logic [XLEN:0] e;
        @(negedge clk);
        eg_if  = reset_n && (m_stage == 0) && if_req_i &&
                 (!d_req_i || (m_starve == STARVE_LIMIT));
        eg_d   = reset_n && (m_stage == 0) && d_req_i && !eg_if;
        erv_if = reset_n && (m_stage == 2) && mem_rvalid_i && !m_owner_d;
        erv_d  = reset_n && (m_stage == 2) && mem_rvalid_i &&  m_owner_d;

        chk("if_gnt",    32'(if_gnt_o),    32'(eg_if));
        chk("d_gnt",     32'(d_gnt_o),     32'(eg_d));
        chk("if_rvalid", 32'(if_rvalid_o), 32'(erv_if));
        chk("d_rvalid",  32'(d_rvalid_o),  32'(erv_d));
        chk("if_rdata",  if_rdata_o,       erv_if ? mem_rdata_i : 32'd0);
        chk("d_rdata",   d_rdata_o,        erv_d  ? mem_rdata_i : 32'd0);
        chk("mem_req",   32'(mem_req_o),   32'(m_stage == 1));
        chk("mem_adr",   mem_adr_o,        m_adr);
        chk("mem_we",    32'(mem_we_o),    32'(m_we));
        chk("mem_wdata", mem_wdata_o,      m_wdata);
        chk("mem_size",  32'(mem_size_o),  32'(m_size));
        chk("state",     32'(dbg_state),   32'(m_stage));

        obs_if_gnt = if_gnt_o;
        obs_d_gnt  = d_gnt_o;

        // scoreboard: every response seen must match the oldest grant
        if (if_rvalid_o || d_rvalid_o) begin
            if (exp_q.size() == 0) begin
                chk("sb_spurious_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_owner", 32'(d_rvalid_o), 32'(e[XLEN]));
            end
        end

        // advance the model
        if (!reset_n) begin
            model_clear();
        end else if (m_stage == 0) begin
            if (eg_if) begin
                m_adr = if_adr_i; m_we = 1'b0; m_wdata = '0; m_size = 3'b010;
                m_owner_d = 1'b0; m_starve = 0; m_stage = 1;
                exp_q.push_back({1'b0, if_adr_i});
            end else if (eg_d) begin
                m_adr = d_adr_i; m_we = d_we_i; m_wdata = d_wdata_i; m_size = d_size_i;
                m_owner_d = 1'b1; m_stage = 1;
                if (if_req_i && m_starve < STARVE_LIMIT) m_starve++;
                exp_q.push_back({1'b1, d_adr_i});
            end
        end else if (m_stage == 1) begin
            if (mem_gnt_i) m_stage = 2;
        end else begin
            if (mem_rvalid_i) m_stage = 0;
        end
        g_if = eg_if;
        g_d  = eg_d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        if_req_i = 1'b0; if_adr_i = '0;
        d_req_i = 1'b0; d_adr_i = '0; d_we_i = 1'b0; d_wdata_i = '0; d_size_i = 3'b000;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    // Let any outstanding transaction finish with no new requests.
    task automatic drain();
        if_req_i = 1'b0; d_req_i = 1'b0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
        repeat (4) cycle();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        model_clear();
        g_if = 1'b0; g_d = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        if_req_i = 1'b1; d_req_i = 1'b1;          // must not be granted in reset
        do_reset();
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        idle_inputs();

        // fetch only, best-case latency
        if_req_i = 1'b1; if_adr_i = 32'h80;
        #1 chk("t1_if_gnt_c0", 32'(if_gnt_o), 32'd1);
        cycle();
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1 chk("t1_mem_req_c1", 32'(mem_req_o), 32'd1);
        chk("t1_mem_adr", mem_adr_o, 32'h80);
        chk("t1_mem_size", 32'(mem_size_o), 32'd2);
        cycle();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        #1 chk("t1_if_rvalid_c2", 32'(if_rvalid_o), 32'd1);
        chk("t1_if_rdata", if_rdata_o, 32'h13);
        cycle();
        mem_rvalid_i = 1'b0;

        // fetch and store in the same cycle: store wins
        if_req_i = 1'b1; if_adr_i = 32'h200;
        d_req_i = 1'b1; d_we_i = 1'b1; d_adr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_size_i = 3'b010;
        #1 chk("t2_d_gnt", 32'(d_gnt_o), 32'd1);
        chk("t2_if_gnt_lose", 32'(if_gnt_o), 32'd0);
        cycle();
        d_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1 chk("t2_mem_we", 32'(mem_we_o), 32'd1);
        chk("t2_mem_adr", mem_adr_o, 32'h100);
        chk("t2_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        cycle();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #1 chk("t2_d_ack", 32'(d_rvalid_o), 32'd1);
        chk("t2_if_wait", 32'(if_gnt_o), 32'd0);
        cycle();
        mem_rvalid_i = 1'b0;
        #1 chk("t2_if_gnt_after", 32'(if_gnt_o), 32'd1);
        cycle();
        drain();

        // both requesters held: four data grants, then one fetch, repeating
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pat_q.push_back(1'b1); pat_q.push_back(1'b1);
            pat_q.push_back(1'b1); pat_q.push_back(1'b1);
            pat_q.push_back(1'b0);
        end
        if_req_i = 1'b1; if_adr_i = 32'h400;
        d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h800; d_size_i = 3'b010;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        for (int c = 0; c < 40 && pat_q.size() > 0; c++) begin
            mem_rdata_i = $urandom;
            cycle();
            if (obs_if_gnt || obs_d_gnt) chk("t3_pattern", 32'(obs_d_gnt), 32'(pat_q.pop_front()));
        end
        chk("t3_grant_count", 32'(pat_q.size()), 32'd0);
        pat_q.delete();
        drain();

        // memory stalls in REQ: request stays stable, no new grants
        d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h44; d_size_i = 3'b000;
        #1 chk("t4_d_gnt", 32'(d_gnt_o), 32'd1);
        cycle();
        d_req_i = 1'b0; if_req_i = 1'b1; if_adr_i = 32'h500;
        repeat (5) begin
            #1 chk("t4_stall_req", 32'(mem_req_o), 32'd1);
            chk("t4_stall_adr", mem_adr_o, 32'h44);
            chk("t4_stall_gnt", 32'(if_gnt_o), 32'd0);
            cycle();
        end
        mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0;

        // reset in RESP, stale response afterwards
        reset_n = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        #1 chk("t5_rst_rvalid", 32'(d_rvalid_o), 32'd0);
        chk("t5_rst_gnt", 32'(if_gnt_o), 32'd0);
        cycle();
        reset_n = 1'b1; if_req_i = 1'b0;
        #1 chk("t5_stale_d_rvalid", 32'(d_rvalid_o), 32'd0);
        chk("t5_stale_if_rvalid", 32'(if_rvalid_o), 32'd0);
        chk("t5_state_idle", 32'(dbg_state), 32'd0);
        chk("t5_mem_adr_zero", mem_adr_o, 32'd0);
        cycle();
        mem_rvalid_i = 1'b0;

        // stray responses in IDLE and REQ
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        #1 chk("t6_idle_stray", 32'(if_rvalid_o | d_rvalid_o), 32'd0);
        cycle();
        if_req_i = 1'b1; if_adr_i = 32'h300;
        cycle();
        if_req_i = 1'b0;
        #1 chk("t6_req_stray", 32'(if_rvalid_o | d_rvalid_o), 32'd0);
        cycle();
        mem_gnt_i = 1'b1;                   // grant with rvalid: rvalid dropped
        #1 chk("t6_gnt_rvalid_drop", 32'(if_rvalid_o), 32'd0);
        cycle();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        cycle();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        #1 chk("t6_real_resp", if_rdata_o, 32'hCAFE_F00D);
        cycle();
        mem_rvalid_i = 1'b0;

        // randomized traffic against the model
        repeat (1500) begin
            if (if_req_i && g_if) if_req_i = 1'b0;
            if (!if_req_i && $urandom_range(0, 99) < 40) begin
                if_req_i = 1'b1;
                if_adr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (d_req_i && g_d) d_req_i = 1'b0;
            if (!d_req_i && $urandom_range(0, 99) < 50) begin
                d_req_i   = 1'b1;
                d_adr_i   = $urandom;
                d_we_i    = 1'($urandom_range(0, 1));
                d_wdata_i = $urandom;
                d_size_i  = 3'($urandom_range(0, 7));
            end
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = ($urandom_range(0, 2) == 0);
            mem_rdata_i  = $urandom;
            reset_n      = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset_n = 1'b1;
        drain();
        chk("final_outstanding", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
